// File: rtl/ej32_pkg.sv
// Shared eJ32 constants and types: address map of the console buffers and
// the memory arbiter state encoding.
package ej32_pkg;

    localparam int unsigned EJ32_ASZ    = 17;
    localparam int unsigned EJ32_TIB    = 'h1000;
    localparam int unsigned EJ32_OBUF   = 'h1400;
    localparam int unsigned EJ32_BSZ    = 'h400;
    localparam int unsigned EJ32_STARVE = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CORE = 2'd1,
        HOST = 2'd2
    } arb_st_t;

endpackage

// File: rtl/ej32_win_chk.sv
// Host window check: writes must land in the input buffer, reads must come
// from the output buffer. Purely combinational.
module ej32_win_chk
    import ej32_pkg::*;
#(
    parameter int unsigned ASZ  = EJ32_ASZ,
    parameter int unsigned TIB  = EJ32_TIB,
    parameter int unsigned OBUF = EJ32_OBUF,
    parameter int unsigned BSZ  = EJ32_BSZ
) (
    input  logic [ASZ-1:0] addr,
    input  logic           we,
    output logic           ok
);

    // One extra bit so a window ending exactly at the top of the space still compares correctly.
    localparam logic [ASZ:0] WR_LO = (ASZ + 1)'(TIB);
    localparam logic [ASZ:0] WR_HI = (ASZ + 1)'(TIB + BSZ);
    localparam logic [ASZ:0] RD_LO = (ASZ + 1)'(OBUF);
    localparam logic [ASZ:0] RD_HI = (ASZ + 1)'(OBUF + BSZ);

    logic [ASZ:0] addr_x;
    logic         wr_ok;
    logic         rd_ok;

    assign addr_x = {1'b0, addr};
    assign wr_ok  = (addr_x >= WR_LO) && (addr_x < WR_HI);
    assign rd_ok  = (addr_x >= RD_LO) && (addr_x < RD_HI);
    assign ok     = we ? wr_ok : rd_ok;

endmodule

// File: rtl/ej32_mem_arb.sv
// Single-port SRAM arbiter between the eJ32 core (with atomic locked bursts)
// and the host console requester, with starvation promotion for the host.
module ej32_mem_arb
    import ej32_pkg::*;
#(
    parameter int unsigned ASZ    = EJ32_ASZ,
    parameter int unsigned TIB    = EJ32_TIB,
    parameter int unsigned OBUF   = EJ32_OBUF,
    parameter int unsigned BSZ    = EJ32_BSZ,
    parameter int unsigned STARVE = EJ32_STARVE
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           core_req,
    input  logic           core_we,
    input  logic           core_lock,
    input  logic [ASZ-1:0] core_addr,
    input  logic [7:0]     core_wdata,
    output logic           core_gnt,
    input  logic           host_req,
    input  logic           host_we,
    input  logic [ASZ-1:0] host_addr,
    input  logic [7:0]     host_wdata,
    output logic           host_gnt,
    output logic           host_err,
    output logic [7:0]     rdata,
    output logic           core_rvalid,
    output logic           host_rvalid,
    output logic [ASZ-1:0] mem_addr,
    output logic           mem_we,
    output logic [7:0]     mem_wdata,
    input  logic [7:0]     mem_rdata
);

    localparam int unsigned   WW       = $clog2(STARVE + 1);
    localparam logic [WW-1:0] STARVE_W = WW'(STARVE);

    arb_st_t       state_q, state_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [1:0]    rd_q, rd_d;
    logic          host_err_q, host_err_d;
    logic          host_ok;
    logic          host_wait;

    ej32_win_chk #(
        .ASZ  (ASZ),
        .TIB  (TIB),
        .OBUF (OBUF),
        .BSZ  (BSZ)
    ) u_win_chk (
        .addr (host_addr),
        .we   (host_we),
        .ok   (host_ok)
    );

    // Grants are combinational (zero latency) and suppressed while in reset.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
        core_gnt = 1'b0;
        host_gnt = 1'b0;
        if (rst) begin
            if (state_q == CORE) begin
                core_gnt = core_req;
            end else if (host_req && (wait_q >= STARVE_W)) begin
                host_gnt = 1'b1;
            end else if (core_req) begin
                core_gnt = 1'b1;
            end else if (host_req) begin
                host_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (core_gnt) begin
            mem_addr  = core_addr;
            mem_we    = core_we;
            mem_wdata = core_wdata;
        end else if (host_gnt) begin
            mem_addr  = host_addr;
            mem_we    = host_we && host_ok;
            mem_wdata = host_wdata;
        end
    end

    assign host_wait = host_req && !host_gnt;

    always_comb begin
        state_d = state_q;
        if (core_gnt) begin
            state_d = core_lock ? CORE : IDLE;
        end else if (host_gnt) begin
            state_d = HOST;
        end else if (state_q == HOST) begin
            state_d = IDLE;
        end

        wait_d = '0;
        if (host_wait) begin
            wait_d = (wait_q == STARVE_W) ? wait_q : wait_q + WW'(1);
        end

        // {core_rd, host_rd}: which requester owns the byte returning next cycle.
        rd_d       = {core_gnt && !core_we, host_gnt && !host_we && host_ok};
        host_err_d = host_gnt && !host_ok;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            wait_q     <= '0;
            rd_q       <= '0;
            host_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            rd_q       <= rd_d;
            host_err_q <= host_err_d;
        end
    end

    assign core_rvalid = rd_q[1];
    assign host_rvalid = rd_q[0];
    assign host_err    = host_err_q;
    assign rdata       = mem_rdata;

endmodule

// File: tb/tb_ej32_mem_arb.sv
// Directed bench for ej32_mem_arb with a behavioural byte SRAM (one-cycle read).
module tb_ej32_mem_arb;

    localparam int ASZ = 17;

    logic           clk;
    logic           rst;
    logic           core_req, core_we, core_lock;
    logic [ASZ-1:0] core_addr;
    logic [7:0]     core_wdata;
    logic           core_gnt;
    logic           host_req, host_we;
    logic [ASZ-1:0] host_addr;
    logic [7:0]     host_wdata;
    logic           host_gnt, host_err;
    logic [7:0]     rdata;
    logic           core_rvalid, host_rvalid;
    logic [ASZ-1:0] mem_addr;
    logic           mem_we;
    logic [7:0]     mem_wdata;
    logic [7:0]     mem_rdata;

    logic [7:0]     mem [0:(1<<ASZ)-1];

    int n_cmp = 0;
    int n_err = 0;

    ej32_mem_arb dut (
        .clk         (clk),
        .rst         (rst),
        .core_req    (core_req),
        .core_we     (core_we),
        .core_lock   (core_lock),
        .core_addr   (core_addr),
        .core_wdata  (core_wdata),
        .core_gnt    (core_gnt),
        .host_req    (host_req),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_gnt    (host_gnt),
        .host_err    (host_err),
        .rdata       (rdata),
        .core_rvalid (core_rvalid),
        .host_rvalid (host_rvalid),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: preload, then read-before-write each rising edge.
    initial begin
        mem[17'h00040] = 8'h5A;
        mem[17'h00100] = 8'h77;
        mem[17'h01400] = 8'hC3;
        mem[17'h02103] = 8'h00;
        mem_rdata      = 8'h00;
        forever begin
            @(posedge clk);
            mem_rdata <= mem[mem_addr];
            if (mem_we) mem[mem_addr] = mem_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_core(input logic req, input logic we, input logic lock,
                              input logic [ASZ-1:0] addr, input logic [7:0] wd);
        core_req   = req;
        core_we    = we;
        core_lock  = lock;
        core_addr  = addr;
        core_wdata = wd;
    endtask

    task automatic drive_host(input logic req, input logic we,
                              input logic [ASZ-1:0] addr, input logic [7:0] wd);
        host_req   = req;
        host_we    = we;
        host_addr  = addr;
        host_wdata = wd;
    endtask

    typedef struct {
        logic [ASZ-1:0] addr;
        logic           we;
        logic           ok;
    } win_vec_t;

    win_vec_t win_tab [8];

    initial begin
        win_tab[0] = '{17'h00100, 1'b1, 1'b0};
        win_tab[1] = '{17'h01010, 1'b1, 1'b1};
        win_tab[2] = '{17'h013FF, 1'b1, 1'b1};
        win_tab[3] = '{17'h01400, 1'b1, 1'b0};
        win_tab[4] = '{17'h00FFF, 1'b1, 1'b0};
        win_tab[5] = '{17'h01400, 1'b0, 1'b1};
        win_tab[6] = '{17'h017FF, 1'b0, 1'b1};
        win_tab[7] = '{17'h01800, 1'b0, 1'b0};

        // Reset with both requesters issuing reads: nothing granted, no rvalid afterwards.
        rst = 1'b0;
        drive_core(1'b1, 1'b0, 1'b1, 17'h00040, 8'h00);
        drive_host(1'b1, 1'b0, 17'h01400, 8'h00);
        advance();
        sample();
        check("rst_core_gnt", core_gnt, 0);
        check("rst_host_gnt", host_gnt, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        advance();
        rst = 1'b1;
        drive_core(1'b0, 1'b0, 1'b0, '0, 8'h00);
        drive_host(1'b0, 1'b0, '0, 8'h00);
        sample();
        check("rst_core_rvalid", core_rvalid, 0);
        check("rst_host_rvalid", host_rvalid, 0);
        check("rst_host_err", host_err, 0);
        advance();

        // Idle core read.
        drive_core(1'b1, 1'b0, 1'b0, 17'h00040, 8'h00);
        sample();
        check("rd_core_gnt", core_gnt, 1);
        check("rd_mem_addr", mem_addr, 17'h00040);
        check("rd_mem_we", mem_we, 0);
        advance();
        drive_core(1'b0, 1'b0, 1'b0, '0, 8'h00);
        sample();
        check("rd_core_rvalid", core_rvalid, 1);
        check("rd_host_rvalid", host_rvalid, 0);
        check("rd_rdata", rdata, 8'h5A);
        advance();

        // Locked 4-beat write burst while the host requests continuously.
        drive_host(1'b1, 1'b1, 17'h01010, 8'h99);
        for (int i = 0; i < 4; i++) begin
            drive_core(1'b1, 1'b1, (i < 3), 17'h02000 + 17'(i), 8'hA0 + 8'(i));
            sample();
            check($sformatf("burst_core_gnt%0d", i), core_gnt, 1);
            check($sformatf("burst_host_gnt%0d", i), host_gnt, 0);
            advance();
        end
        drive_core(1'b0, 1'b0, 1'b0, '0, 8'h00);
        sample();
        check("burst_host_gnt4", host_gnt, 1);
        check("burst_host_mem_we", mem_we, 1);
        check("burst_host_addr", mem_addr, 17'h01010);
        advance();
        drive_host(1'b0, 1'b0, '0, 8'h00);
        sample();
        for (int i = 0; i < 4; i++)
            check($sformatf("burst_mem%0d", i), mem[17'h02000 + 17'(i)], 8'hA0 + 8'(i));
        check("burst_host_mem", mem[17'h01010], 8'h99);
        advance();

        // Starvation against unlocked back-to-back core reads.
        drive_core(1'b1, 1'b0, 1'b0, 17'h00040, 8'h00);
        drive_host(1'b1, 1'b0, 17'h01400, 8'h00);
        for (int i = 0; i < 8; i++) begin
            sample();
            check($sformatf("starve_core_gnt%0d", i), core_gnt, 1);
            check($sformatf("starve_host_gnt%0d", i), host_gnt, 0);
            advance();
        end
        sample();
        check("starve_host_win", host_gnt, 1);
        check("starve_core_lose", core_gnt, 0);
        check("starve_host_addr", mem_addr, 17'h01400);
        advance();
        sample();
        check("starve_host_rvalid", host_rvalid, 1);
        check("starve_rdata", rdata, 8'hC3);
        check("starve_clear_core", core_gnt, 1);
        check("starve_clear_host", host_gnt, 0);
        advance();
        drive_core(1'b0, 1'b0, 1'b0, '0, 8'h00);
        drive_host(1'b0, 1'b0, '0, 8'h00);
        advance();

        // Starved host must wait out a long locked burst, then beat the core.
        drive_host(1'b1, 1'b0, 17'h01400, 8'h00);
        for (int i = 0; i < 10; i++) begin
            drive_core(1'b1, 1'b0, (i < 9), 17'h00040, 8'h00);
            sample();
            check($sformatf("lock_host_gnt%0d", i), host_gnt, 0);
            advance();
        end
        drive_core(1'b1, 1'b0, 1'b0, 17'h00040, 8'h00);
        sample();
        check("unlock_host_win", host_gnt, 1);
        check("unlock_core_lose", core_gnt, 0);
        advance();
        drive_host(1'b0, 1'b0, '0, 8'h00);
        sample();
        check("unlock_core_next", core_gnt, 1);
        check("unlock_host_rvalid", host_rvalid, 1);
        advance();
        drive_core(1'b0, 1'b0, 1'b0, '0, 8'h00);
        advance();

        // Host window boundaries.
        foreach (win_tab[k]) begin
            drive_host(1'b1, win_tab[k].we, win_tab[k].addr, 8'h55);
            sample();
            check($sformatf("win_gnt%0d", k), host_gnt, 1);
            check($sformatf("win_mem_we%0d", k), mem_we, win_tab[k].we && win_tab[k].ok);
            advance();
            drive_host(1'b0, 1'b0, '0, 8'h00);
            sample();
            check($sformatf("win_err%0d", k), host_err, !win_tab[k].ok);
            check($sformatf("win_rvalid%0d", k), host_rvalid, !win_tab[k].we && win_tab[k].ok);
            advance();
        end
        sample();
        check("win_err_clear", host_err, 0);
        check("win_mem_0100", mem[17'h00100], 8'h77);
        check("win_mem_1010", mem[17'h01010], 8'h55);
        check("win_mem_1400", mem[17'h01400], 8'hC3);
        advance();

        // Simultaneous start with the wait counter at zero.
        drive_core(1'b1, 1'b0, 1'b0, 17'h00040, 8'h00);
        drive_host(1'b1, 1'b0, 17'h017FF, 8'h00);
        sample();
        check("sim_core_gnt", core_gnt, 1);
        check("sim_host_gnt", host_gnt, 0);
        advance();
        drive_core(1'b0, 1'b0, 1'b0, '0, 8'h00);
        sample();
        check("sim_host_next", host_gnt, 1);
        check("sim_core_rvalid", core_rvalid, 1);
        advance();
        drive_host(1'b0, 1'b0, '0, 8'h00);
        advance();

        // Reset during a locked write burst.
        drive_host(1'b1, 1'b1, 17'h01020, 8'h42);
        for (int i = 0; i < 3; i++) begin
            drive_core(1'b1, 1'b1, 1'b1, 17'h02100 + 17'(i), 8'hB0 + 8'(i));
            sample();
            check($sformatf("mid_core_gnt%0d", i), core_gnt, 1);
            advance();
        end
        rst = 1'b0;
        drive_core(1'b1, 1'b1, 1'b1, 17'h02103, 8'hB3);
        sample();
        check("mid_rst_core_gnt", core_gnt, 0);
        check("mid_rst_host_gnt", host_gnt, 0);
        check("mid_rst_mem_we", mem_we, 0);
        advance();
        rst = 1'b1;
        drive_core(1'b0, 1'b0, 1'b0, '0, 8'h00);
        sample();
        check("mid_rel_host_gnt", host_gnt, 1);
        check("mid_rel_core_gnt", core_gnt, 0);
        check("mid_rel_core_rvalid", core_rvalid, 0);
        check("mid_rel_host_rvalid", host_rvalid, 0);
        advance();
        drive_host(1'b0, 1'b0, '0, 8'h00);
        sample();
        check("mid_mem_2102", mem[17'h02102], 8'hB2);
        check("mid_mem_2103", mem[17'h02103], 8'h00);
        check("mid_mem_1020", mem[17'h01020], 8'h42);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
